// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank: AXI4-Lite slave exposing RW control registers, RO status words and a version word.
module axi_lite_reg_bank #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CTRL = 4,
  parameter int NUM_STAT = 2,
  parameter logic [NUM_CTRL*32-1:0] CTRL_RESET = '0,
  parameter logic [31:0] VERSION = 32'h1100_0000,
  localparam int SW = (NUM_STAT > 0) ? NUM_STAT : 1
) (
  input  logic                     i_axi_clk,
  input  logic                     i_axi_rst,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [ADDR_WIDTH-1:0]    i_awaddr,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_wstrb,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  output logic [1:0]               o_bresp,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [ADDR_WIDTH-1:0]    i_araddr,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [1:0]               o_rresp,
  output logic [31:0]              o_rdata,
  output logic [NUM_CTRL*32-1:0]   o_ctrl,
  output logic [NUM_CTRL-1:0]      o_ctrl_wr_stb,
  input  logic [SW*32-1:0]         i_status,
  output logic [SW-1:0]            o_stat_rd_stb
);
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_WIDTH-3:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [NUM_CTRL*32-1:0] ctrl_q, ctrl_d;
  logic [NUM_CTRL-1:0] wr_stb_q, wr_stb_d;
  logic [SW-1:0] rd_stb_q, rd_stb_d;
  logic [31:0] widx, ridx;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_awaddr[1:0], i_araddr[1:0]};
  assign widx = 32'(awaddr_q);
  assign ridx = 32'(i_araddr[ADDR_WIDTH-1:2]);
  assign o_awready = (w_state_q == W_IDLE) && !aw_got_q;
  assign o_wready = (w_state_q == W_IDLE) && !w_got_q;
  assign o_bvalid = w_state_q == W_RESP;
  assign o_bresp = bresp_q;
  assign o_arready = r_state_q == R_IDLE;
  assign o_rvalid = r_state_q == R_DATA;
  assign o_rresp = rresp_q;
  assign o_rdata = rdata_q;
  assign o_ctrl = ctrl_q;
  assign o_ctrl_wr_stb = wr_stb_q;
  assign o_stat_rd_stb = rd_stb_q;
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_got_q <= 1'b0;
      w_got_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= '0;
      ctrl_q <= CTRL_RESET;
      wr_stb_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rd_stb_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_got_q <= aw_got_d;
      w_got_q <= w_got_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      ctrl_q <= ctrl_d;
      wr_stb_q <= wr_stb_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rd_stb_q <= rd_stb_d;
    end
  end
  // AW and W are latched independently; the commit happens the cycle after both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d = aw_got_q;
    w_got_d = w_got_q;
    awaddr_d = awaddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    bresp_d = bresp_q;
    ctrl_d = ctrl_q;
    wr_stb_d = '0;
    if (w_state_q == W_RESP) begin
      w_state_d = i_bready ? W_IDLE : W_RESP;
    end else if (aw_got_q && w_got_q) begin
      aw_got_d = 1'b0;
      w_got_d = 1'b0;
      w_state_d = W_RESP;
      bresp_d = (widx < 32'(NUM_CTRL)) ? 2'b00 : 2'b10;
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (widx == 32'(k)) begin
          wr_stb_d[k] = 1'b1;
          for (int b = 0; b < 4; b++)
            if (wstrb_q[b]) ctrl_d[32*k+8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end else begin
      if (i_awvalid && !aw_got_q) begin
        aw_got_d = 1'b1;
        awaddr_d = i_awaddr[ADDR_WIDTH-1:2];
      end
      if (i_wvalid && !w_got_q) begin
        w_got_d = 1'b1;
        wdata_d = i_wdata;
        wstrb_d = i_wstrb;
      end
    end
  end
  // Read data is taken from ctrl_q, so a read racing a write commit sees the old value.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rd_stb_d = '0;
    if (r_state_q == R_DATA) begin
      r_state_d = i_rready ? R_IDLE : R_DATA;
    end else if (i_arvalid) begin
      r_state_d = R_DATA;
      rdata_d = '0;
      rresp_d = (ridx <= 32'(NUM_CTRL + NUM_STAT)) ? 2'b00 : 2'b10;
      for (int k = 0; k < NUM_CTRL; k++)
        if (ridx == 32'(k)) rdata_d = ctrl_q[32*k +: 32];
      for (int j = 0; j < NUM_STAT; j++) begin
        if (ridx == 32'(NUM_CTRL + j)) begin
          rdata_d = i_status[32*j +: 32];
          rd_stb_d[j] = 1'b1;
        end
      end
      if (ridx == 32'(NUM_CTRL + NUM_STAT)) rdata_d = VERSION;
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// tb_axi_lite_reg_bank: scoreboard bench for axi_lite_reg_bank with a small register model.
module tb_axi_lite_reg_bank;
  localparam logic [127:0] CR = 128'h4444_0004_3333_0003_2222_0002_1111_0001;
  localparam logic [31:0] VER = 32'h1100_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0, ctrl_wr_stb;
  logic [1:0] bresp, rresp, stat_rd_stb;
  logic [127:0] ctrl;
  logic [63:0] status = '0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_ctrl [4];
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  int stb_cnt = 0, st_cnt = 0;
  logic [3:0] stb_log = '0;
  logic [1:0] st_log = '0;
  always #5 clk = ~clk;
  axi_lite_reg_bank #(.ADDR_WIDTH(16), .NUM_CTRL(4), .NUM_STAT(2), .CTRL_RESET(CR), .VERSION(VER)) dut (
    .i_axi_clk(clk), .i_axi_rst(rst),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
    .o_rvalid(rvalid), .i_rready(rready), .o_rresp(rresp), .o_rdata(rdata),
    .o_ctrl(ctrl), .o_ctrl_wr_stb(ctrl_wr_stb), .i_status(status), .o_stat_rd_stb(stat_rd_stb)
  );
  always @(negedge clk) begin
    if (|ctrl_wr_stb) begin
      stb_cnt++;
      stb_log |= ctrl_wr_stb;
    end
    if (|stat_rd_stb) begin
      st_cnt++;
      st_log |= stat_rd_stb;
    end
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_ctrl[k] = CR[32*k +: 32];
  endtask
  function automatic logic [127:0] model_flat();
    return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
  endfunction
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int bwait);
    int idx, t;
    bit a_ok, w_ok, hs_a, hs_w;
    logic [1:0] got;
    idx = int'(addr >> 2);
    bq.push_back((idx < 4) ? 2'b00 : 2'b10);
    if (idx < 4)
      for (int b = 0; b < 4; b++) if (strb[b]) m_ctrl[idx][8*b +: 8] = data[8*b +: 8];
    stb_cnt = 0;
    stb_log = '0;
    awaddr = addr;
    wdata = data;
    wstrb = strb;
    wvalid = 1'b1;
    a_ok = 0;
    w_ok = 0;
    t = 0;
    while (!(a_ok && w_ok) && t < 50) begin
      if (t >= w_lead && !a_ok) awvalid = 1'b1;
      hs_a = awvalid && awready;
      hs_w = wvalid && wready;
      @(negedge clk);
      if (hs_a) begin a_ok = 1; awvalid = 1'b0; end
      if (hs_w) begin w_ok = 1; wvalid = 1'b0; end
      if (w_ok && !a_ok) chk("wready_drop", wready, 1'b0);
      t++;
    end
    if (!(a_ok && w_ok)) chk("aw_w_handshake_timeout", 0, 1);
    t = 0;
    while (!bvalid && t < 10) begin @(negedge clk); t++; end
    chk("b_latency", t, 1);
    repeat (bwait) begin
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, bq[0]);
      chk("no_accept_in_resp", {awready, wready}, 2'b00);
      @(negedge clk);
    end
    got = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bresp", got, bq.pop_front());
    chk("bvalid_clear", bvalid, 1'b0);
    chk("ready_reraise", {awready, wready}, 2'b11);
    chk("wr_stb_count", stb_cnt, (idx < 4) ? 1 : 0);
    chk("wr_stb_mask", stb_log, (idx < 4) ? (4'b1 << idx) : 4'b0);
    chk("ctrl_vs_model", ctrl, model_flat());
  endtask
  task automatic axi_read(input logic [15:0] addr, input int rwait);
    int idx, t;
    bit hs;
    logic [33:0] got;
    logic [1:0] st_exp;
    idx = int'(addr >> 2);
    st_exp = (idx == 4) ? 2'b01 : (idx == 5) ? 2'b10 : 2'b00;
    if (idx < 4) rq.push_back({2'b00, m_ctrl[idx]});
    else if (idx < 6) rq.push_back({2'b00, status[32*(idx-4) +: 32]});
    else if (idx == 6) rq.push_back({2'b00, VER});
    else rq.push_back({2'b10, 32'h0});
    st_cnt = 0;
    st_log = '0;
    araddr = addr;
    arvalid = 1'b1;
    hs = 0;
    t = 0;
    while (!hs && t < 20) begin
      hs = arready;
      @(negedge clk);
      t++;
    end
    arvalid = 1'b0;
    if (!hs) chk("ar_handshake_timeout", 0, 1);
    chk("rvalid_set", rvalid, 1'b1);
    chk("arready_drop", arready, 1'b0);
    repeat (rwait) begin
      chk("rdata_hold", {rresp, rdata}, rq[0]);
      @(negedge clk);
    end
    got = {rresp, rdata};
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rresp_rdata", got, rq.pop_front());
    chk("rvalid_clear", rvalid, 1'b0);
    chk("arready_reraise", arready, 1'b1);
    chk("stat_stb_count", st_cnt, (st_exp != 0) ? 1 : 0);
    chk("stat_stb_mask", st_log, st_exp);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", ctrl, CR);
    chk("rst_readys", {awready, wready, arready}, 3'b111);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    chk("rst_strobes", {ctrl_wr_stb, stat_rd_stb}, 6'h0);
    axi_read(16'h0018, 0);
    axi_read(16'h0000, 1);
    axi_write(16'h0004, 32'hDEAD_BEEF, 4'b1111, 0, 0);
    chk("ctrl1_deadbeef", ctrl[63:32], 32'hDEAD_BEEF);
    axi_write(16'h0000, 32'h1122_3344, 4'b1111, 0, 0);
    axi_write(16'h0003, 32'hAABB_CCDD, 4'b0101, 0, 1);
    chk("ctrl0_partial", ctrl[31:0], 32'h11BB_33DD);
    axi_write(16'h0008, 32'h5A5A_0F0F, 4'b1111, 5, 3);
    axi_write(16'h0010, 32'hFFFF_FFFF, 4'b1111, 0, 0);
    axi_write(16'h0050, 32'hFFFF_FFFF, 4'b1111, 2, 1);
    axi_write(16'h0018, 32'h0, 4'b1111, 0, 0);
    axi_read(16'h0050, 0);
    axi_read(16'h0004, 0);
    axi_read(16'h0008, 2);
    status = 64'h0000_00A5_1234_5678;
    axi_read(16'h0014, 4);
    axi_read(16'h0010, 0);
    axi_write(16'h000C, 32'hFFFF_FFFF, 4'b0000, 1, 0);
    araddr = 16'h0014;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("pre_rst_rvalid", rvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rvalid", rvalid, 1'b0);
    chk("async_rst_rdata", rdata, 32'h0);
    chk("async_rst_ctrl", ctrl, CR);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_resp", {rvalid, bvalid}, 2'b00);
    end
    axi_read(16'h0000, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
